// File: rtl/regfile_sb.sv
// regfile_sb: register file with two write ports (ALU and load return),
// combinational read forwarding, a single-entry load scoreboard and a
// separately written 5-bit status flag register.
module regfile_sb #(
   parameter int DATA_WIDTH = 16,
   parameter int REGBITS    = 4,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [REGBITS-1:0]    wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flag_wr_en,
   input  logic [4:0]            flags_in,
   output logic [4:0]            flags,
   input  logic [REGBITS-1:0]    rd_addr1,
   input  logic [REGBITS-1:0]    rd_addr2,
   output logic [DATA_WIDTH-1:0] rd_data1,
   output logic [DATA_WIDTH-1:0] rd_data2,
   output logic                  rd_busy1,
   output logic                  rd_busy2,
   output logic                  ld_ready,
   input  logic                  ld_issue,
   input  logic [REGBITS-1:0]    ld_addr,
   input  logic                  ld_done,
   input  logic [DATA_WIDTH-1:0] ld_data
);

   localparam int NREGS = 1 << REGBITS;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic                  pending_q, pending_d;
   logic [REGBITS-1:0]    tag_q, tag_d;
   logic                  squash_q, squash_d;
   logic [4:0]            flags_q, flags_d;

   logic retire;        // outstanding load completes this cycle
   logic ld_accept;     // new load reservation taken this cycle
   logic alu_we;        // ALU write actually lands in the array
   logic ld_we;         // load return actually lands in the array
   logic ld_fwd_ok;     // load data is live and may be forwarded
   logic tag_is_zero;   // reservation targets the hardwired zero register

   assign retire      = ld_done && pending_q;
   assign ld_accept   = ld_issue && (!pending_q || retire);
   assign tag_is_zero = ZR && (tag_q == '0);
   assign alu_we      = wr_en && !(ZR && (wr_addr == '0));
   assign ld_fwd_ok   = retire && !squash_q;
   // ALU write to the same register in the completion cycle wins over the load
   assign ld_we       = ld_fwd_ok && !tag_is_zero && !(wr_en && (wr_addr == tag_q));

   assign ld_ready = !pending_q;
   assign flags    = flags_q;

   // Read a register with zero-register, ALU and load-return forwarding applied
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REGBITS-1:0] a);
      logic [DATA_WIDTH-1:0] v;
      if (ZR && (a == '0))
         v = '0;
      else if (wr_en && (wr_addr == a))
         v = wr_data;
      else if (ld_fwd_ok && (tag_q == a))
         v = ld_data;
      else
         v = regs_q[a];
      return v;
   endfunction

   // Operand is waiting on a load that has not returned yet
   function automatic logic busy_port(input logic [REGBITS-1:0] a);
      return pending_q && !squash_q && (tag_q == a) && !ld_done && !tag_is_zero;
   endfunction

   // Combinational read ports and busy indications
   always_comb begin
      rd_data1 = read_port(rd_addr1);
      rd_data2 = read_port(rd_addr2);
      rd_busy1 = busy_port(rd_addr1);
      rd_busy2 = busy_port(rd_addr2);
   end

   // Scoreboard and flag next-state: retire first, then accept a new issue
   always_comb begin
      pending_d = pending_q;
      tag_d     = tag_q;
      squash_d  = squash_q;
      flags_d   = flags_q;
      if (retire)
         pending_d = 1'b0;
      if (pending_q && !ld_done && wr_en && (wr_addr == tag_q))
         squash_d = 1'b1;
      if (ld_accept) begin
         pending_d = 1'b1;
         tag_d     = ld_addr;
         squash_d  = 1'b0;
      end
      if (flag_wr_en)
         flags_d = flags_in;
   end

   // Control state registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= 1'b0;
         tag_q     <= '0;
         squash_q  <= 1'b0;
         flags_q   <= '0;
      end else begin
         pending_q <= pending_d;
         tag_q     <= tag_d;
         squash_q  <= squash_d;
         flags_q   <= flags_d;
      end
   end

   // Register array: ALU port and load-return port, both may write per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
      end else begin
         if (ld_we)
            regs_q[tag_q] <= ld_data;
         if (alu_we)
            regs_q[wr_addr] <= wr_data;
      end
   end

endmodule
